// File: rtl/mini_logger_drain.sv
// Drains the ring-buffer logger oldest-entry-first over a valid/ready stream,
// one logger read per data section, holding logging frozen while busy.
module mini_logger_drain #(
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int LOG_DATA_W     = 128,
    parameter int PADDING_W      = 128,
    parameter int OUTPUT_W       = 64,
    parameter int MEM_WIDTH      = LOG_DATA_W + PADDING_W,
    parameter int MEM_ADDR_W     = $clog2(MEM_WIDTH/8) + MEM_DEPTH_LOG2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_val,
    output logic                      start_rdy,
    input  logic [MEM_ADDR_W-1:0]     curr_wr_addr,
    input  logic                      has_looped,
    output logic                      log_freeze,
    output logic                      rd_req_val,
    output logic [MEM_ADDR_W-1:0]     rd_req_addr,
    input  logic                      rd_resp_val,
    input  logic [OUTPUT_W-1:0]       rd_resp_data,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [OUTPUT_W-1:0]       out_data,
    output logic                      out_entry_last,
    output logic                      out_last,
    output logic [MEM_DEPTH_LOG2:0]   entry_count,
    output logic                      done
);

    localparam int WORD_SECT_W = $clog2(OUTPUT_W/8);
    localparam int TOP_SECT    = MEM_WIDTH/OUTPUT_W - 1;
    localparam int LOW_SECT    = PADDING_W/OUTPUT_W;
    localparam int SECT_W      = (TOP_SECT > 0) ? $clog2(TOP_SECT + 1) : 1;
    localparam int LINE_SHIFT  = MEM_ADDR_W - MEM_DEPTH_LOG2;
    localparam int CNT_W       = MEM_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, FIN} state_t;

    state_t                    state, state_nxt;
    logic [MEM_DEPTH_LOG2-1:0] line;
    logic [SECT_W-1:0]         sect;
    logic [CNT_W-1:0]          remaining;
    logic [CNT_W-1:0]          entry_count_r;
    logic [OUTPUT_W-1:0]       out_data_r;
    logic                      out_entry_last_r;
    logic                      out_last_r;

    logic [MEM_DEPTH_LOG2-1:0] wr_line;
    logic [CNT_W-1:0]          snap_count;
    logic                      sect_is_low;
    logic                      unused_addr_bits;

    assign wr_line          = curr_wr_addr[MEM_ADDR_W-1 -: MEM_DEPTH_LOG2];
    assign unused_addr_bits = ^curr_wr_addr[LINE_SHIFT-1:0];
    assign snap_count       = has_looped ? (CNT_W'(1) << MEM_DEPTH_LOG2) : {1'b0, wr_line};
    assign sect_is_low      = (sect == SECT_W'(LOW_SECT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_val) state_nxt = (snap_count == '0) ? FIN : REQ;
            REQ:  state_nxt = WAIT;
            WAIT: if (rd_resp_val) state_nxt = OUT;
            OUT:  if (out_rdy) begin
                      if (!sect_is_low)             state_nxt = REQ;
                      else if (remaining == CNT_W'(1)) state_nxt = FIN;
                      else                          state_nxt = REQ;
                  end
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_rdy   = (state == IDLE);
        log_freeze  = (state != IDLE);
        rd_req_val  = (state == REQ);
        out_val     = (state == OUT);
        done        = (state == FIN);
        rd_req_addr = '0;
        if (state == REQ)
            rd_req_addr = (MEM_ADDR_W'(line) << LINE_SHIFT) | (MEM_ADDR_W'(sect) << WORD_SECT_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line             <= '0;
            sect             <= '0;
            remaining        <= '0;
            entry_count_r    <= '0;
            out_data_r       <= '0;
            out_entry_last_r <= 1'b0;
            out_last_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_val) begin
                    line          <= has_looped ? wr_line : '0;
                    sect          <= SECT_W'(TOP_SECT);
                    remaining     <= snap_count;
                    entry_count_r <= snap_count;
                end
                WAIT: if (rd_resp_val) begin
                    out_data_r       <= rd_resp_data;
                    out_entry_last_r <= sect_is_low;
                    out_last_r       <= sect_is_low && (remaining == CNT_W'(1));
                end
                OUT: if (out_rdy) begin
                    if (!sect_is_low) begin
                        sect <= sect - SECT_W'(1);
                    end else begin
                        sect      <= SECT_W'(TOP_SECT);
                        line      <= line + MEM_DEPTH_LOG2'(1);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data       = out_data_r;
    assign out_entry_last = out_entry_last_r;
    assign out_last       = out_last_r;
    assign entry_count    = entry_count_r;

endmodule
